// File: rtl/bti_tcm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bti_pkg / bti_req_if_t / bti_rsp_if_t                                      |
// | BTI packet types and the request/response channel interfaces.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef BTI_TIDW
`define BTI_TIDW 4
`endif

package bti_pkg;
    localparam int TIDW = `BTI_TIDW;

    localparam logic [1:0] BTI_CMD_READ  = 2'd0;
    localparam logic [1:0] BTI_CMD_WRITE = 2'd1;

    typedef struct packed {
        logic [TIDW-1:0] tid;
        logic [1:0]      cmd;
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [3:0]      strobe;
    } bti_req_pkt_t;

    typedef struct packed {
        logic [TIDW-1:0] tid;
        logic [31:0]     data;
        logic            ok;
    } bti_rsp_pkt_t;
endpackage

interface bti_req_if_t;
    import bti_pkg::*;
    logic         vld;
    logic         rdy;
    bti_req_pkt_t pkt;

    modport slv (input vld, input pkt, output rdy);
    modport mst (output vld, output pkt, input rdy);
endinterface

interface bti_rsp_if_t;
    import bti_pkg::*;
    logic         vld;
    logic         rdy;
    bti_rsp_pkt_t pkt;

    modport slv (input vld, input pkt, output rdy);
    modport mst (output vld, output pkt, input rdy);
endinterface

`default_nettype wire

// File: rtl/bti_tcm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bti_tcm                                                                    |
// | BTI slave over a single-port word TCM; in-order 2-credit response queue.   |
// | Optional macro BTI_TCM_ERR_CHK_EN: range/alignment checking of addresses.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module bti_tcm
    import bti_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    bti_req_if_t.slv bti_req_slv,
    bti_rsp_if_t.mst bti_rsp_mst
);

    localparam int unsigned C_IDXW = $clog2(DEPTH);

    logic [31:0]        mem [DEPTH];
    logic [31:0]        rd_data_q;

    bti_req_pkt_t       req_pkt;
    logic               req_rdy;
    logic               accept;
    logic               is_rd;
    logic               is_wr;
    logic               addr_ok;
    logic               wr_en;
    logic               rd_en;
    logic [C_IDXW-1:0]  idx;

    logic               rsp_vld;
    bti_rsp_pkt_t       rsp_pkt;
    logic               pop;
    logic               q_empty;
    logic               push;
    logic               q_pop;
    logic [31:0]        stg_data;

    logic               stg_vld_q, stg_vld_d;
    logic               stg_rd_q,  stg_rd_d;
    logic               stg_ok_q,  stg_ok_d;
    logic [TIDW-1:0]    stg_tid_q, stg_tid_d;

    logic [1:0]         cnt_q,    cnt_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [TIDW-1:0]    q_tid_q  [2];
    logic [TIDW-1:0]    q_tid_d  [2];
    logic [31:0]        q_data_q [2];
    logic [31:0]        q_data_d [2];
    logic               q_ok_q   [2];
    logic               q_ok_d   [2];

    assign req_pkt = bti_req_slv.pkt;
    assign idx     = req_pkt.addr[C_IDXW+1:2];
    assign is_rd   = (req_pkt.cmd == BTI_CMD_READ);
    assign is_wr   = (req_pkt.cmd == BTI_CMD_WRITE);

`ifdef BTI_TCM_ERR_CHK_EN
    assign addr_ok = ({32'h0, req_pkt.addr} >= {32'h0, BASE_ADDR})
                  && ({32'h0, req_pkt.addr} < ({32'h0, BASE_ADDR} + 64'(DEPTH) * 64'd4))
                  && (req_pkt.addr[1:0] == 2'b00);
`else
    logic unused_addr;
    assign addr_ok     = 1'b1;
    assign unused_addr = ^{req_pkt.addr[31:C_IDXW+2], req_pkt.addr[1:0], BASE_ADDR};
`endif

    // One credit per free queue slot, counting the access in flight.
    assign req_rdy = (({1'b0, cnt_q} + {2'b00, stg_vld_q}) < 3'd2);
    assign accept  = bti_req_slv.vld & req_rdy;
    assign wr_en   = accept & is_wr & addr_ok & ~rst;
    assign rd_en   = accept & is_rd & addr_ok;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (req_pkt.strobe[b]) begin
                    mem[idx][8*b +: 8] <= req_pkt.data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[idx];
        end
    end

    assign stg_data = stg_rd_q ? rd_data_q : 32'h0;
    assign q_empty  = (cnt_q == 2'd0);
    assign pop      = rsp_vld & bti_rsp_mst.rdy;
    assign q_pop    = pop & ~q_empty;
    // With the queue empty the stage drives the response directly and is retired on pop.
    assign push     = stg_vld_q & ~(pop & q_empty);

    always_comb begin
        stg_vld_d = accept;
        stg_rd_d  = accept & is_rd & addr_ok;
        stg_ok_d  = accept & (is_rd | is_wr) & addr_ok;
        stg_tid_d = accept ? req_pkt.tid : stg_tid_q;

        cnt_d     = cnt_q + {1'b0, push} - {1'b0, q_pop};
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        q_tid_d   = q_tid_q;
        q_data_d  = q_data_q;
        q_ok_d    = q_ok_q;

        if (push) begin
            q_tid_d[wr_ptr_q]  = stg_tid_q;
            q_data_d[wr_ptr_q] = stg_data;
            q_ok_d[wr_ptr_q]   = stg_ok_q;
            wr_ptr_d           = ~wr_ptr_q;
        end
        if (q_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld_q <= 1'b0;
            stg_rd_q  <= 1'b0;
            stg_ok_q  <= 1'b0;
            stg_tid_q <= '0;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_tid_q[i]  <= '0;
                q_data_q[i] <= 32'h0;
                q_ok_q[i]   <= 1'b0;
            end
        end else begin
            stg_vld_q <= stg_vld_d;
            stg_rd_q  <= stg_rd_d;
            stg_ok_q  <= stg_ok_d;
            stg_tid_q <= stg_tid_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            q_tid_q   <= q_tid_d;
            q_data_q  <= q_data_d;
            q_ok_q    <= q_ok_d;
        end
    end

    always_comb begin
        rsp_vld = ~q_empty | stg_vld_q;
        rsp_pkt = '0;
        if (!q_empty) begin
            rsp_pkt.tid  = q_tid_q[rd_ptr_q];
            rsp_pkt.data = q_data_q[rd_ptr_q];
            rsp_pkt.ok   = q_ok_q[rd_ptr_q];
        end else if (stg_vld_q) begin
            rsp_pkt.tid  = stg_tid_q;
            rsp_pkt.data = stg_data;
            rsp_pkt.ok   = stg_ok_q;
        end
    end

    assign bti_req_slv.rdy = req_rdy;
    assign bti_rsp_mst.vld = rsp_vld;
    assign bti_rsp_mst.pkt = rsp_pkt;

endmodule

`default_nettype wire

// File: tb/tb_bti_tcm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bti_tcm                                                                 |
// | Directed table, corner sequences and random traffic against a TCM model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_bti_tcm;
    import bti_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bti_req_if_t req_if ();
    bti_rsp_if_t rsp_if ();

    bti_tcm #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .bti_req_slv (req_if.slv),
        .bti_rsp_mst (rsp_if.mst)
    );

    typedef struct {
        logic [TIDW-1:0] tid;
        logic [31:0]     data;
        logic            ok;
    } exp_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        ok;
        logic [31:0] rdata;
    } vec_t;

    int              n_chk = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              n_acc = 0;
    int              n_rsp = 0;
    int              acc_cyc = 0;
    int              rsp_cyc = 0;
    logic            acc_now = 1'b0;
    logic [31:0]     got_data;
    logic            got_ok;
    logic            prev_stall = 1'b0;
    bti_rsp_pkt_t    prev_pkt;
    exp_t            exp_q[$];
    logic [31:0]     ref_mem [DEPTH];
    vec_t            tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit addr_legal(input logic [31:0] a);
`ifdef BTI_TCM_ERR_CHK_EN
        longint unsigned lo;
        longint unsigned hi;
        lo = longint'(BASE);
        hi = lo + longint'(DEPTH) * 4;
        return (longint'(a) >= lo) && (longint'(a) < hi) && (a % 4 == 0);
`else
        return (a == a);
`endif
    endfunction

    // Reference: each accepted request takes effect in order, at acceptance.
    task automatic model_accept(input bti_req_pkt_t p);
        exp_t        e;
        int unsigned w;
        e.tid  = p.tid;
        e.data = 32'h0;
        e.ok   = 1'b0;
        w      = (p.addr / 4) % DEPTH;
        if ((p.cmd == BTI_CMD_READ || p.cmd == BTI_CMD_WRITE) && addr_legal(p.addr)) begin
            e.ok = 1'b1;
            if (p.cmd == BTI_CMD_READ) begin
                e.data = ref_mem[w];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (p.strobe[b]) ref_mem[w][8*b +: 8] = p.data[8*b +: 8];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        bti_rsp_pkt_t rp;
        exp_t         e;
        @(negedge clk);
        rp      = rsp_if.pkt;
        acc_now = req_if.vld && req_if.rdy && !rst;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("rsp_vld_hold", 64'(rsp_if.vld), 64'd1);
                check("rsp_tid_hold", 64'(rp.tid), 64'(prev_pkt.tid));
                check("rsp_data_hold", 64'(rp.data), 64'(prev_pkt.data));
                check("rsp_ok_hold", 64'(rp.ok), 64'(prev_pkt.ok));
            end
            if (rsp_if.vld && rsp_if.rdy) begin
                n_rsp++;
                rsp_cyc  = cyc;
                got_data = rp.data;
                got_ok   = rp.ok;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_tid", 64'(rp.tid), 64'(e.tid));
                    check("rsp_data", 64'(rp.data), 64'(e.data));
                    check("rsp_ok", 64'(rp.ok), 64'(e.ok));
                end
            end
            prev_stall = rsp_if.vld && !rsp_if.rdy;
            prev_pkt   = rp;
            if (acc_now) begin
                model_accept(req_if.pkt);
                n_acc++;
                acc_cyc = cyc;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_req(input logic [1:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input int tid);
        req_if.pkt.tid    = tid[TIDW-1:0];
        req_if.pkt.cmd    = cmd;
        req_if.pkt.addr   = addr;
        req_if.pkt.data   = data;
        req_if.pkt.strobe = strb;
    endtask

    task automatic do_txn(input logic [1:0] cmd, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input int tid);
        int t;
        int r0;
        r0 = n_rsp;
        set_req(cmd, addr, data, strb, tid);
        req_if.vld = 1'b1;
        t = 0;
        do begin
            cycle();
            t++;
        end while (!acc_now && t < 20);
        req_if.vld = 1'b0;
        if (!acc_now) check("accept_timeout", 64'd0, 64'd1);
        t = 0;
        while (n_rsp == r0 && t < 20) begin
            cycle();
            t++;
        end
        if (n_rsp == r0) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        int c0;
        int t;
        int tid;

        tbl[0]  = '{BTI_CMD_WRITE, 32'h10,  32'hDEADBEEF, 4'hF, 1'b1, 32'h0};
        tbl[1]  = '{BTI_CMD_READ,  32'h10,  32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{BTI_CMD_WRITE, 32'h20,  32'h11223344, 4'hF, 1'b1, 32'h0};
        tbl[3]  = '{BTI_CMD_WRITE, 32'h20,  32'hAABBCCDD, 4'h5, 1'b1, 32'h0};
        tbl[4]  = '{BTI_CMD_READ,  32'h20,  32'h0,        4'h0, 1'b1, 32'h11BB33DD};
        tbl[5]  = '{BTI_CMD_WRITE, 32'h20,  32'hFFFFFFFF, 4'h0, 1'b1, 32'h0};
        tbl[6]  = '{BTI_CMD_READ,  32'h20,  32'h0,        4'h0, 1'b1, 32'h11BB33DD};
        tbl[7]  = '{2'd2,          32'h20,  32'h55555555, 4'hF, 1'b0, 32'h0};
        tbl[8]  = '{2'd3,          32'h20,  32'h66666666, 4'hF, 1'b0, 32'h0};
        tbl[9]  = '{BTI_CMD_WRITE, 32'hFFC, 32'h0BADF00D, 4'hF, 1'b1, 32'h0};
        tbl[10] = '{BTI_CMD_READ,  32'hFFC, 32'h0,        4'h0, 1'b1, 32'h0BADF00D};
        tbl[11] = '{BTI_CMD_WRITE, 32'h0,   32'h12345678, 4'hF, 1'b1, 32'h0};
`ifdef BTI_TCM_ERR_CHK_EN
        tbl[12] = '{BTI_CMD_READ,  32'h1000, 32'h0,        4'h0, 1'b0, 32'h0};
        tbl[13] = '{BTI_CMD_WRITE, 32'h3,    32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        tbl[14] = '{BTI_CMD_READ,  32'h0,    32'h0,        4'h0, 1'b1, 32'h12345678};
`else
        tbl[12] = '{BTI_CMD_READ,  32'h1000, 32'h0,        4'h0, 1'b1, 32'h12345678};
        tbl[13] = '{BTI_CMD_WRITE, 32'h3,    32'hCAFEF00D, 4'hF, 1'b1, 32'h0};
        tbl[14] = '{BTI_CMD_READ,  32'h0,    32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
`endif

        rst        = 1'b1;
        req_if.vld = 1'b0;
        req_if.pkt = '0;
        rsp_if.rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rsp_vld", 64'(rsp_if.vld), 64'd0);
        check("rst_rsp_tid", 64'(rsp_if.pkt.tid), 64'd0);
        check("rst_rsp_data", 64'(rsp_if.pkt.data), 64'd0);
        check("rst_rsp_ok", 64'(rsp_if.pkt.ok), 64'd0);
        check("rst_req_rdy", 64'(req_if.rdy), 64'd1);

        rsp_if.rdy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            do_txn(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].strb, i);
            check($sformatf("tbl%0d_ok", i), 64'(got_ok), 64'(tbl[i].ok));
            check($sformatf("tbl%0d_data", i), 64'(got_data), 64'(tbl[i].rdata));
            check($sformatf("tbl%0d_latency", i), 64'(rsp_cyc - acc_cyc), 64'd1);
        end

        // Backpressure: only two credits, then drain in order.
        rsp_if.rdy = 1'b0;
        a0  = n_acc;
        tid = 0;
        set_req(BTI_CMD_READ, 32'h10, 32'h0, 4'h0, tid);
        req_if.vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (acc_now) begin
                tid++;
                set_req(BTI_CMD_READ, (tid % 2 == 0) ? 32'h10 : 32'h20, 32'h0, 4'h0, tid);
            end
        end
        check("bp_accepts", 64'(n_acc - a0), 64'd2);
        check("bp_req_rdy_low", 64'(req_if.rdy), 64'd0);
        rsp_if.rdy = 1'b1;
        t = 0;
        while (n_acc - a0 < 5 && t < 30) begin
            cycle();
            t++;
            if (acc_now) begin
                tid++;
                set_req(BTI_CMD_READ, (tid % 2 == 0) ? 32'h10 : 32'h20, 32'h0, 4'h0, tid);
            end
        end
        req_if.vld = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            cycle();
            t++;
        end
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_total_accepts", 64'(n_acc - a0), 64'd5);

        // Sixteen back-to-back reads.
        a0 = n_acc;
        r0 = n_rsp;
        c0 = cyc;
        tid = 0;
        set_req(BTI_CMD_READ, 32'h10, 32'h0, 4'h0, tid);
        req_if.vld = 1'b1;
        t = 0;
        while (n_acc - a0 < 16 && t < 40) begin
            cycle();
            t++;
            if (acc_now) begin
                tid++;
                set_req(BTI_CMD_READ, (tid % 2 == 0) ? 32'h10 : 32'h20, 32'h0, 4'h0, tid);
            end
        end
        req_if.vld = 1'b0;
        check("b2b_cycles", 64'(cyc - c0), 64'd16);
        repeat (3) cycle();
        check("b2b_responses", 64'(n_rsp - r0), 64'd16);

        // Reset with two responses queued.
        rsp_if.rdy = 1'b0;
        a0 = n_acc;
        set_req(BTI_CMD_READ, 32'h10, 32'h0, 4'h0, 7);
        req_if.vld = 1'b1;
        t = 0;
        while (n_acc - a0 < 2 && t < 10) begin
            cycle();
            t++;
        end
        req_if.vld = 1'b0;
        repeat (2) cycle();
        check("pre_rst_rsp_vld", 64'(rsp_if.vld), 64'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("post_rst_rsp_vld", 64'(rsp_if.vld), 64'd0);
        rsp_if.rdy = 1'b1;
        r0 = n_rsp;
        repeat (5) cycle();
        check("post_rst_no_stale", 64'(n_rsp - r0), 64'd0);

        // A write presented while rst is high must not land.
        set_req(BTI_CMD_WRITE, 32'h10, 32'h99999999, 4'hF, 3);
        req_if.vld = 1'b1;
        rst        = 1'b1;
        cycle();
        req_if.vld = 1'b0;
        rst        = 1'b0;
        check("rst_write_rsp_vld", 64'(rsp_if.vld), 64'd0);
        do_txn(BTI_CMD_READ, 32'h10, 32'h0, 4'h0, 4);
        check("rst_write_dropped", 64'(got_data), 64'hDEADBEEF);

        // Random traffic against the model.
        for (int k = 0; k < 16; k++)
            do_txn(BTI_CMD_WRITE, 32'h100 + 32'(4 * k), $urandom, 4'hF, k);
        acc_now = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!req_if.vld || acc_now) begin
                int unsigned r;
                logic [31:0] a;
                logic [1:0]  c;
                r = $urandom_range(0, 15);
                c = (r < 7) ? BTI_CMD_READ : (r < 13) ? BTI_CMD_WRITE : 2'(r[0] + 2);
                a = 32'h100 + 32'(4 * $urandom_range(0, 15));
`ifdef BTI_TCM_ERR_CHK_EN
                if ($urandom_range(0, 7) == 0)
                    a = ($urandom_range(0, 1) == 0) ? a + DEPTH * 4 : a + 32'($urandom_range(1, 3));
`else
                if ($urandom_range(0, 3) == 0)
                    a = a + (32'($urandom_range(1, 255)) << 12) + 32'($urandom_range(0, 3));
`endif
                set_req(c, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                req_if.vld = ($urandom_range(0, 3) != 0);
            end
            rsp_if.rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_if.vld = 1'b0;
        rsp_if.rdy = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            cycle();
            t++;
        end
        check("random_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
